// File: rtl/mem_access_unit.sv
// Load/store sequencer between the memory stage and a word-organised data RAM.
// Splits word-crossing accesses into several RAM cycles and extends load data.
module mem_access_unit #(
   parameter logic [31:0] MEM_BASE  = 32'h0001_0000,
   parameter logic [31:0] MEM_LIMIT = 32'h0002_0000,
   parameter logic [5:0]  NOP_CODE  = 6'h3f,
   parameter logic [5:0]  ALU_SB    = 6'h10,
   parameter logic [5:0]  ALU_SH    = 6'h11,
   parameter logic [5:0]  ALU_SW    = 6'h12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [5:0]  mem_alucode,
   input  logic [31:0] mem_rdata
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LD0  = 3'd1;
   localparam logic [2:0] S_LD1  = 3'd2;
   localparam logic [2:0] S_ST   = 3'd3;
   localparam logic [2:0] S_RESP = 3'd4;

   logic [2:0]  state;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [1:0]  size_q;
   logic        store_q;
   logic        uns_q;
   logic        cross_q;
   logic        err_q;
   logic [63:0] buf_q;
   logic [1:0]  cnt_q;

   logic [2:0]  req_n;
   logic [32:0] req_end;
   logic        req_err;
   logic        req_cross;
   logic        last_byte;
   logic [31:0] shifted;
   logic [7:0]  store_byte;
   logic [31:0] load_data;

   // Request derivation; 33-bit end address so a 32-bit wrap lands out of range.
   always_comb begin
      // NOTE: every variable gets a default first so no latch is inferred.
      req_n = 3'd4;
      case (req_size)
         2'd0:    req_n = 3'd1;
         2'd1:    req_n = 3'd2;
         default: req_n = 3'd4;
      endcase
   end

   assign req_end   = {1'b0, req_addr} + 33'(req_n) - 33'd1;
   assign req_err   = (req_size == 2'd3) || (req_addr < MEM_BASE) ||
                      (req_end >= {1'b0, MEM_LIMIT});
   assign req_cross = ({1'b0, req_addr[1:0]} + req_n) > 3'd4;

   // Only halves and words can cross, so the last split byte index is 1 or 3.
   assign last_byte = (cnt_q == ((size_q == 2'd1) ? 2'd1 : 2'd3));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= '0;
         store_q <= 1'b0;
         uns_q   <= 1'b0;
         cross_q <= 1'b0;
         err_q   <= 1'b0;
         buf_q   <= '0;
         cnt_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register update on the same edge.
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  size_q  <= req_size;
                  store_q <= req_store;
                  uns_q   <= req_unsigned;
                  cross_q <= req_cross;
                  err_q   <= req_err;
                  buf_q   <= '0;
                  cnt_q   <= '0;
                  if (req_err)        state <= S_RESP;
                  else if (req_store) state <= S_ST;
                  else                state <= S_LD0;
               end
            end
            S_LD0: begin
               buf_q[31:0] <= mem_rdata;
               state       <= cross_q ? S_LD1 : S_RESP;
            end
            S_LD1: begin
               buf_q[63:32] <= mem_rdata;
               state        <= S_RESP;
            end
            S_ST: begin
               if (!cross_q || last_byte) state <= S_RESP;
               else                       cnt_q <= cnt_q + 2'd1;
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign shifted    = 32'(buf_q >> {addr_q[1:0], 3'b000});
   assign store_byte = 8'(wdata_q >> {cnt_q, 3'b000});

   always_comb begin
      load_data = shifted;
      case (size_q)
         2'd0:    load_data = uns_q ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
         2'd1:    load_data = uns_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

   assign req_ready  = (state == S_IDLE);
   assign resp_valid = (state == S_RESP);
   assign resp_err   = resp_valid && err_q;
   assign resp_rdata = (resp_valid && !err_q && !store_q) ? load_data : 32'd0;

   // RAM port decodes only from registered state.
   always_comb begin
      mem_addr    = 32'd0;
      mem_wdata   = 32'd0;
      mem_alucode = NOP_CODE;
      case (state)
         S_LD0: mem_addr = {addr_q[31:2], 2'b00};
         S_LD1: mem_addr = {addr_q[31:2], 2'b00} + 32'd4;
         S_ST: begin
            if (cross_q) begin
               mem_addr    = addr_q + 32'(cnt_q);
               mem_wdata   = {24'd0, store_byte};
               mem_alucode = ALU_SB;
            end else begin
               mem_addr  = addr_q;
               mem_wdata = wdata_q;
               case (size_q)
                  2'd0:    mem_alucode = ALU_SB;
                  2'd1:    mem_alucode = ALU_SH;
                  default: mem_alucode = ALU_SW;
               endcase
            end
         end
         default: begin
            mem_addr    = 32'd0;
            mem_wdata   = 32'd0;
            mem_alucode = NOP_CODE;
         end
      endcase
   end

endmodule
